// File: rtl/axis_byte_packer.sv
// rtl/axis_byte_packer.sv - packs a byte stream into WORD_WIDTH-bit AXI-Stream words, first byte in MSBs.
// Optional partial-word idle timeout enabled by defining AXIS_BYTE_PACKER_TIMEOUT_EN.
module axis_byte_packer #(
    parameter int WORD_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [WORD_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int NUM_BYTES = WORD_WIDTH / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    generate
        if (WORD_WIDTH < 8 || (WORD_WIDTH % 8) != 0) begin : g_bad_width
            $error("axis_byte_packer: WORD_WIDTH must be a multiple of 8 and >= 8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("axis_byte_packer: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] out_q, out_d;
    logic                  m_valid_q, m_valid_d;
    logic [WORD_WIDTH-1:0] word_d;
    logic                  last_byte, in_hs, out_hs, flush;

    // Only the completing byte can stall: earlier bytes land in asm_q, not out_q.
    assign last_byte     = (cnt_q == LAST_CNT);
    assign s_axis_tready = arstn & (~last_byte | ~m_valid_q | m_axis_tready);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_valid_q & m_axis_tready;
    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = m_valid_q;

`ifdef AXIS_BYTE_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; a handshake always wins.
    assign flush = (cnt_q != '0) && !in_hs && (idle_q == IDLE_LAST);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            idle_q <= '0;
        end else if (cnt_q == '0 || in_hs || flush) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    generate
        if (NUM_BYTES == 1) begin : g_single
            assign word_d = s_axis_tdata;
        end else begin : g_multi
            localparam int ASM_W = (NUM_BYTES - 1) * 8;
            logic [ASM_W-1:0] asm_q, asm_d;

            always_comb begin
                asm_d = asm_q;
                if (in_hs && !last_byte) begin
                    for (int k = 0; k < NUM_BYTES - 1; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            asm_d[(NUM_BYTES-2-k)*8 +: 8] = s_axis_tdata;
                        end
                    end
                end else if (flush) begin
                    asm_d = '0;
                end
            end

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    asm_q <= '0;
                end else begin
                    asm_q <= asm_d;
                end
            end

            assign word_d = {asm_q, s_axis_tdata};
        end
    endgenerate

    always_comb begin
        cnt_d     = cnt_q;
        out_d     = out_q;
        m_valid_d = m_valid_q;
        if (in_hs) begin
            cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
        end else if (flush) begin
            cnt_d = '0;
        end
        // Completion takes priority over a drain so back-to-back words have no bubble.
        if (in_hs && last_byte) begin
            out_d     = word_d;
            m_valid_d = 1'b1;
        end else if (out_hs) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q     <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// tb/tb_axis_byte_packer.sv - directed self-checking bench for axis_byte_packer (24-bit and 8-bit builds).
module tb_axis_byte_packer;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [7:0]  s_tdata24 = '0, s_tdata8 = '0;
    logic        s_tvalid24 = 1'b0, s_tvalid8 = 1'b0;
    logic        s_tready24, s_tready8;
    logic [23:0] m_tdata24;
    logic [7:0]  m_tdata8;
    logic        m_tvalid24, m_tvalid8;
    logic        m_tready24 = 1'b1, m_tready8 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] words_q[$];

    always #5 clk = ~clk;

    axis_byte_packer #(.WORD_WIDTH(24), .TIMEOUT_CYCLES(16)) u_dut24 (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(s_tdata24), .s_axis_tvalid(s_tvalid24), .s_axis_tready(s_tready24),
        .m_axis_tdata(m_tdata24), .m_axis_tvalid(m_tvalid24), .m_axis_tready(m_tready24)
    );

    axis_byte_packer #(.WORD_WIDTH(8), .TIMEOUT_CYCLES(16)) u_dut8 (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(s_tdata8), .s_axis_tvalid(s_tvalid8), .s_axis_tready(s_tready8),
        .m_axis_tdata(m_tdata8), .m_axis_tvalid(m_tvalid8), .m_axis_tready(m_tready8)
    );

    always @(negedge clk) begin
        if (arstn && m_tvalid24 && m_tready24) words_q.push_back(m_tdata24);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        arstn = 1'b0;
        nxt();
        arstn = 1'b1;
    endtask

    task automatic run_gap(input int gap, input logic [23:0] exp_word, input string tag);
        words_q.delete();
        s_tvalid24 = 1'b1; s_tdata24 = 8'hAA;
        nxt();
        s_tvalid24 = 1'b0;
        repeat (gap) nxt();
        s_tvalid24 = 1'b1;
        s_tdata24 = 8'h01; nxt();
        s_tdata24 = 8'h02; nxt();
        s_tdata24 = 8'h03; nxt();
        s_tvalid24 = 1'b0;
        nxt(); nxt();
        check({tag, "_count"}, words_q.size(), 1);
        if (words_q.size() > 0) check({tag, "_word"}, words_q[0], exp_word);
        pulse_reset();
    endtask

    initial begin
        // Reset state
        s_tvalid24 = 1'b1; s_tdata24 = 8'h55;
        @(posedge clk); @(negedge clk);
        check("rst_m_valid", m_tvalid24, 0);
        check("rst_m_data", m_tdata24, 0);
        check("rst_s_ready", s_tready24, 0);
        check("rst_m_valid8", m_tvalid8, 0);
        s_tvalid24 = 1'b0;
        arstn = 1'b1;
        nxt();
        check("post_rst_valid", m_tvalid24, 0);

        // Single word with open downstream
        m_tready24 = 1'b1;
        s_tvalid24 = 1'b1;
        s_tdata24 = 8'hAB; #1 check("t1_ready0", s_tready24, 1); nxt();
        check("t1_valid_early", m_tvalid24, 0);
        s_tdata24 = 8'hCD; nxt();
        s_tdata24 = 8'hEF; nxt();
        s_tvalid24 = 1'b0;
        check("t1_valid", m_tvalid24, 1);
        check("t1_data", m_tdata24, 24'hABCDEF);
        nxt();
        check("t1_valid_once", m_tvalid24, 0);
        check("t1_data_hold", m_tdata24, 24'hABCDEF);

        // Backpressure: last byte stalls, then completes with zero gap
        m_tready24 = 1'b0;
        s_tvalid24 = 1'b1;
        s_tdata24 = 8'hAB; nxt();
        s_tdata24 = 8'hCD; nxt();
        s_tdata24 = 8'hEF; nxt();
        check("t2_valid", m_tvalid24, 1);
        check("t2_data", m_tdata24, 24'hABCDEF);
        s_tdata24 = 8'h11; #1 check("t2_rdy_b0", s_tready24, 1); nxt();
        s_tdata24 = 8'h22; #1 check("t2_rdy_b1", s_tready24, 1); nxt();
        s_tdata24 = 8'h33; #1 check("t2_rdy_b2_stall", s_tready24, 0); nxt();
        check("t2_hold_valid", m_tvalid24, 1);
        check("t2_hold_data", m_tdata24, 24'hABCDEF);
        check("t2_still_stall", s_tready24, 0);
        m_tready24 = 1'b1;
        #1 check("t2_rdy_release", s_tready24, 1);
        nxt();
        s_tvalid24 = 1'b0;
        check("t2_next_valid", m_tvalid24, 1);
        check("t2_next_data", m_tdata24, 24'h112233);
        nxt();
        check("t2_drained", m_tvalid24, 0);

        // Continuous stream 0x00..0x0B
        for (int i = 0; i < 12; i++) begin
            logic [23:0] w;
            w = {8'(i - 3), 8'(i - 2), 8'(i - 1)};
            if (i >= 3 && (i % 3) == 0) begin
                check("t3_valid", m_tvalid24, 1);
                check("t3_data", m_tdata24, w);
            end else if (i > 0) begin
                check("t3_gap", m_tvalid24, 0);
            end
            s_tvalid24 = 1'b1; s_tdata24 = 8'(i);
            #1 check("t3_ready", s_tready24, 1);
            nxt();
        end
        s_tvalid24 = 1'b0;
        check("t3_last_valid", m_tvalid24, 1);
        check("t3_last_data", m_tdata24, 24'h090A0B);
        nxt();
        check("t3_end", m_tvalid24, 0);

        // Reset mid-word
        s_tvalid24 = 1'b1;
        s_tdata24 = 8'hAA; nxt();
        s_tdata24 = 8'hBB; nxt();
        s_tvalid24 = 1'b0;
        arstn = 1'b0;
        #1 check("t4_rst_valid", m_tvalid24, 0);
        check("t4_rst_ready", s_tready24, 0);
        nxt();
        arstn = 1'b1;
        s_tvalid24 = 1'b1;
        s_tdata24 = 8'h01; nxt();
        s_tdata24 = 8'h02; nxt();
        s_tdata24 = 8'h03; nxt();
        s_tvalid24 = 1'b0;
        check("t4_valid", m_tvalid24, 1);
        check("t4_data", m_tdata24, 24'h010203);
        nxt();

        // Partial-word timeout behaviour
        run_gap(15, 24'hAA0102, "t5_gap15");
`ifdef AXIS_BYTE_PACKER_TIMEOUT_EN
        run_gap(16, 24'h010203, "t5_gap16_timeout");
`else
        run_gap(16, 24'hAA0102, "t5_gap16_hold");
`endif

        // 8-bit build: one registered stage
        m_tready8 = 1'b1;
        s_tvalid8 = 1'b1; s_tdata8 = 8'h5A;
        #1 check("t6_ready", s_tready8, 1);
        nxt();
        s_tvalid8 = 1'b0;
        check("t6_valid", m_tvalid8, 1);
        check("t6_data", m_tdata8, 8'h5A);
        nxt();
        check("t6_drained", m_tvalid8, 0);
        m_tready8 = 1'b0;
        s_tvalid8 = 1'b1; s_tdata8 = 8'h3C;
        #1 check("t6_ready_empty", s_tready8, 1);
        nxt();
        check("t6_held_valid", m_tvalid8, 1);
        check("t6_held_data", m_tdata8, 8'h3C);
        s_tdata8 = 8'h77;
        #1 check("t6_ready_full", s_tready8, 0);
        nxt();
        check("t6_still_data", m_tdata8, 8'h3C);
        m_tready8 = 1'b1;
        #1 check("t6_ready_drain", s_tready8, 1);
        nxt();
        s_tvalid8 = 1'b0;
        check("t6_b2b_valid", m_tvalid8, 1);
        check("t6_b2b_data", m_tdata8, 8'h77);
        nxt();
        check("t6_end_valid", m_tvalid8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
